// File: rtl/recorder_pkg.sv
// Shared types and record-layout helpers for change_recorder.
// Records hold the timestamp in the MSBs and the probe snapshot in the LSBs.
package recorder_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      CAPTURE = 2'd2,
      DRAIN   = 2'd3
   } rec_state_t;

   localparam int DEF_CHANNELS    = 8;
   localparam int DEF_TIME_LENGTH = 24;
   localparam int DEF_DEPTH       = 16;

   // Probe slice always starts at bit 0; the timestamp slice sits just above it.
   localparam int PROBE_LSB = 0;

   function automatic int rec_width(input int time_length, input int channels);
      return time_length + channels;
   endfunction

   function automatic int ts_lsb(input int channels);
      return PROBE_LSB + channels;
   endfunction

endpackage

// File: rtl/change_recorder_probe_sync.sv
// probe_sync: per-channel 2-flop synchroniser for the asynchronous probe inputs.
module probe_sync #(
   parameter int CHANNELS = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] probes,
   output logic [CHANNELS-1:0] psync
);

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_sync
         logic meta_reg;
         logic sync_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               meta_reg <= 1'b0;
               sync_reg <= 1'b0;
            end else begin
               meta_reg <= probes[gi];
               sync_reg <= meta_reg;
            end
         end

         assign psync[gi] = sync_reg;
      end
   endgenerate

endmodule

// File: rtl/change_recorder.sv
// change_recorder: change-compressed probe capture into a fall-through FIFO.
// Optional per-channel change mask enabled by defining CHANGE_RECORDER_MASK_EN.
module change_recorder
   import recorder_pkg::*;
#(
   parameter int CHANNELS    = DEF_CHANNELS,
   parameter int TIME_LENGTH = DEF_TIME_LENGTH,
   parameter int DEPTH       = DEF_DEPTH
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            run,
   input  logic [TIME_LENGTH-1:0]          timestamp,
   input  logic [CHANNELS-1:0]             probes,
`ifdef CHANGE_RECORDER_MASK_EN
   input  logic [CHANNELS-1:0]             chan_mask,
`endif
   output logic [TIME_LENGTH+CHANNELS-1:0] rec_data,
   output logic                            rec_valid,
   input  logic                            rec_ready,
   output logic                            overflow,
   output logic [$clog2(DEPTH):0]          level,
   output logic                            busy
);

   localparam int REC_W  = rec_width(TIME_LENGTH, CHANNELS);
   localparam int TS_LSB = ts_lsb(CHANNELS);
   localparam int AW     = $clog2(DEPTH);

   logic [CHANNELS-1:0]    psync;
   logic [TIME_LENGTH-1:0] ts_q_reg;
   logic [CHANNELS-1:0]    last_rec_reg;
   rec_state_t             state_reg, state_next;

   logic             push, flush, pop, full, wr_en;
   logic [REC_W-1:0] push_data;
   logic             step, wrap, changed;

   logic [REC_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             overflow_reg;

   probe_sync #(.CHANNELS(CHANNELS)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .probes(probes),
      .psync (psync)
   );

   assign step = (timestamp != ts_q_reg);
   assign wrap = step && (timestamp < ts_q_reg);

`ifdef CHANGE_RECORDER_MASK_EN
   assign changed = ((psync & ~chan_mask) != (last_rec_reg & ~chan_mask));
`else
   assign changed = (psync != last_rec_reg);
`endif

   always_comb begin
      state_next = state_reg;
      push       = 1'b0;
      flush      = 1'b0;
      push_data  = '0;
      push_data[TS_LSB +: TIME_LENGTH] = timestamp;
      push_data[PROBE_LSB +: CHANNELS] = psync;
      case (state_reg)
         IDLE: begin
            if (run) begin
               flush      = 1'b1;
               state_next = ARM;
            end
         end
         ARM: begin
            if (!run) begin
               state_next = IDLE;
            end else if (step) begin
               push       = 1'b1;
               state_next = CAPTURE;
            end
         end
         CAPTURE: begin
            // The closing record replaces any record a coincident step would produce.
            if (!run) begin
               push       = 1'b1;
               push_data[TS_LSB +: TIME_LENGTH] = ts_q_reg;
               state_next = DRAIN;
            end else if (step && (changed || wrap)) begin
               push = 1'b1;
            end
         end
         DRAIN: begin
            if (count_reg == '0) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign full  = (count_reg == (AW+1)'(DEPTH));
   assign pop   = (count_reg != '0) && rec_ready;
   assign wr_en = push && !full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         ts_q_reg     <= '0;
         last_rec_reg <= '0;
      end else begin
         state_reg <= state_next;
         ts_q_reg  <= timestamp;
         if (push) begin
            last_rec_reg <= psync;
         end
      end
   end

   // A push into a full FIFO is dropped even when a pop frees a slot that cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else if (flush) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({wr_en, pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
         if (push && full) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   assign rec_valid = (count_reg != '0);
   assign rec_data  = rec_valid ? mem[rd_ptr_reg] : '0;
   assign overflow  = overflow_reg;
   assign level     = count_reg;
   assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_change_recorder.sv
// Directed bench for change_recorder; expected records are queued as stimulus is
// driven and compared when the DUT presents them on the readout handshake.
module tb_change_recorder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run;
   logic [23:0] timestamp;
   logic [7:0]  probes;
   logic [31:0] rec_data;
   logic        rec_valid;
   logic        rec_ready;
   logic        overflow;
   logic [4:0]  level;
   logic        busy;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   change_recorder #(.CHANNELS(8), .TIME_LENGTH(24), .DEPTH(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (run),
      .timestamp(timestamp),
      .probes   (probes),
      .rec_data (rec_data),
      .rec_valid(rec_valid),
      .rec_ready(rec_ready),
      .overflow (overflow),
      .level    (level),
      .busy     (busy)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 200 && busy !== 1'b0; i++) tick(1);
      check(tag, 64'(busy), 64'd0);
   endtask

   task automatic wait_empty(input string tag);
      for (int i = 0; i < 200 && level !== 5'd0; i++) tick(1);
      check(tag, 64'(level), 64'd0);
   endtask

   task automatic set_ts(input logic [23:0] t);
      timestamp = t;
      tick(4);
   endtask

   // Scoreboard side: every accepted record must match the head of the queue.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && rec_valid === 1'b1 && rec_ready === 1'b1) begin
         vectors++;
         assert (exp_q.size() != 0) else begin
            miscompares++;
            $error("FAIL unexpected_rec observed=%0h expected=none", rec_data);
         end
         if (exp_q.size() != 0) check("rec", 64'(rec_data), 64'(exp_q.pop_front()));
      end
   end

   initial begin
      rst_n = 1'b0; run = 1'b0; timestamp = '0; probes = '0; rec_ready = 1'b1;
      #3;
      check("rst_valid", 64'(rec_valid), 64'd0);
      check("rst_data", 64'(rec_data), 64'd0);
      check("rst_level", 64'(level), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_ovf", 64'(overflow), 64'd0);
      tick(2);
      rst_n = 1'b1;
      tick(1);

      // Constant probes: only the first step and the closing record.
      run = 1'b1;
      tick(4);
      check("arm_busy", 64'(busy), 64'd1);
      check("arm_level", 64'(level), 64'd0);
      exp_q.push_back({24'd1, 8'h00});
      for (int t = 1; t <= 9; t++) set_ts(24'(t));
      run = 1'b0;
      exp_q.push_back({24'd9, 8'h00});
      wait_idle("t1_idle");
      check("t1_queue_empty", 64'(exp_q.size()), 64'd0);

      // Probe changes become visible at the following step.
      run = 1'b1; timestamp = 24'd0;
      tick(4);
      exp_q.push_back({24'd1, 8'h00});
      set_ts(24'd1);
      set_ts(24'd2);
      timestamp = 24'd3; probes = 8'hA5; tick(4);
      exp_q.push_back({24'd4, 8'hA5});
      set_ts(24'd4);
      set_ts(24'd5);
      timestamp = 24'd6; probes = 8'h00; tick(4);
      exp_q.push_back({24'd7, 8'h00});
      set_ts(24'd7);
      set_ts(24'd8);
      run = 1'b0;
      exp_q.push_back({24'd8, 8'h00});
      wait_idle("t2_idle");
      check("t2_queue_empty", 64'(exp_q.size()), 64'd0);

      // Timestamp wrap forces a keep-alive record with unchanged probes.
      run = 1'b1; timestamp = 24'hFFFFFD; probes = 8'h3C;
      tick(4);
      exp_q.push_back({24'hFFFFFE, 8'h3C});
      set_ts(24'hFFFFFE);
      set_ts(24'hFFFFFF);
      exp_q.push_back({24'h000000, 8'h3C});
      set_ts(24'h000000);
      set_ts(24'h000001);
      run = 1'b0;
      exp_q.push_back({24'h000001, 8'h3C});
      wait_idle("t3_idle");
      check("t3_queue_empty", 64'(exp_q.size()), 64'd0);

      // Overflow: 21 pushes with the consumer stalled, first 16 must survive.
      rec_ready = 1'b0; run = 1'b1; timestamp = 24'd0; probes = 8'h00;
      tick(4);
      exp_q.push_back({24'd1, 8'h00});
      set_ts(24'd1);
      for (int i = 0; i < 20; i++) begin
         probes = 8'(i + 1);
         tick(3);
         timestamp = 24'(i + 2);
         tick(1);
         if (i < 15) exp_q.push_back({24'(i + 2), 8'(i + 1)});
      end
      check("ovf_level", 64'(level), 64'd16);
      check("ovf_flag", 64'(overflow), 64'd1);
      rec_ready = 1'b1;
      wait_empty("ovf_drain");
      check("ovf_sticky", 64'(overflow), 64'd1);
      run = 1'b0;
      exp_q.push_back({24'd21, 8'h14});
      wait_idle("t4_idle");
      check("t4_queue_empty", 64'(exp_q.size()), 64'd0);

      // Next run rise clears overflow; then fill and push/pop on a full FIFO.
      run = 1'b1; timestamp = 24'd0;
      tick(2);
      check("ovf_cleared", 64'(overflow), 64'd0);
      rec_ready = 1'b0;
      tick(2);
      exp_q.push_back({24'd1, 8'h14});
      set_ts(24'd1);
      for (int i = 0; i < 15; i++) begin
         probes = 8'h40 + 8'(i);
         tick(3);
         timestamp = 24'(i + 2);
         tick(1);
         exp_q.push_back({24'(i + 2), 8'h40 + 8'(i)});
      end
      check("full_level", 64'(level), 64'd16);
      check("full_no_ovf", 64'(overflow), 64'd0);
      probes = 8'h80;
      tick(3);
      timestamp = 24'd17; rec_ready = 1'b1;
      tick(1);
      rec_ready = 1'b0;
      check("pushpop_level", 64'(level), 64'd15);
      check("pushpop_ovf", 64'(overflow), 64'd1);
      rec_ready = 1'b1;
      wait_empty("t5_drain");
      check("t5_queue_empty", 64'(exp_q.size()), 64'd0);

      // Asynchronous reset mid-capture discards queued records at once.
      rec_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         probes = 8'h90 + 8'(i);
         tick(3);
         timestamp = 24'(18 + i);
         tick(1);
      end
      check("pre_rst_level", 64'(level), 64'd5);
      check("pre_rst_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(rec_valid), 64'd0);
      check("mid_rst_level", 64'(level), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_ovf", 64'(overflow), 64'd0);
      run = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
      check("post_rst_valid", 64'(rec_valid), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
